// File: rtl/DesignPkg.sv
// Shared types and constants for the configurable UART transmitter.
// Holds the FSM encoding, parity modes and small decode helpers.
package DesignPkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_cfg_fsm_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    localparam int UART_MIN_CLKS_PER_BIT = 2;

    // Code 3 is reserved and behaves as no parity.
    function automatic uart_parity_e decode_parity(input logic [1:0] code);
        uart_parity_e p;
        case (code)
            2'd1:    p = PAR_EVEN;
            2'd2:    p = PAR_ODD;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

    // Mask selecting the low (dbits+5) data bits.
    function automatic logic [7:0] data_mask(input logic [1:0] dbits);
        return 8'hFF >> (2'd3 - dbits);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Push is ignored when full; pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a transmit FIFO.
// Frame format is captured per byte so frames stream without gaps.
module uart_tx_cfg
    import DesignPkg::*;
#(
    parameter int FIFO_DEPTH         = 16,
    parameter int DIV_W              = 16,
    parameter int RESET_CLKS_PER_BIT = 434,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_byte_in,
    input  logic [DIV_W-1:0] cfg_clks_per_bit,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic             tx_serial_out,
    output logic             tx_active,
    output logic             tx_done,
    output logic [LVL_W-1:0] fifo_level
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || RESET_CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_param_check
        $error("uart_tx_cfg: bad FIFO_DEPTH or RESET_CLKS_PER_BIT");
    end

    uart_tx_cfg_fsm_e r_state;
    uart_tx_cfg_fsm_e w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_idx_nxt;
    logic             r_stop_sec;
    logic             w_stop_sec_nxt;
    logic             r_line;
    logic             w_line_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [7:0]       r_data;
    logic [DIV_W-1:0] r_n;
    logic [1:0]       r_dbits;
    uart_parity_e     r_par;
    logic             r_stop2;

    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_rdata;
    logic [DIV_W-1:0] w_n_cfg;
    logic             w_bit_end;
    logic             w_last_bit;
    logic             w_last_stop;
    logic             w_parity_bit;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (tx_valid),
        .i_wdata (tx_byte_in),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign tx_ready      = !w_full;
    assign tx_serial_out = r_line;
    assign tx_done       = r_done;
    assign tx_active     = (r_state == START) || (r_state == DATA)
                        || (r_state == PARITY) || (r_state == STOP);

    assign w_n_cfg = (cfg_clks_per_bit < DIV_W'(UART_MIN_CLKS_PER_BIT))
                   ? DIV_W'(UART_MIN_CLKS_PER_BIT) : cfg_clks_per_bit;
    assign w_bit_end    = (r_cnt == r_n - DIV_W'(1));
    assign w_last_bit   = (r_bit_idx == 3'(r_dbits) + 3'd4);
    assign w_last_stop  = !r_stop2 || r_stop_sec;
    assign w_parity_bit = (^(r_data & data_mask(r_dbits))) ^ (r_par == PAR_ODD);

    // Next-state, bit counters, pop request and end-of-frame lookahead.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_bit_idx;
        w_stop_sec_nxt = r_stop_sec;
        w_pop          = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (w_last_bit) begin
                        w_stop_sec_nxt = 1'b0;
                        w_state_nxt = (r_par == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        w_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt    = STOP;
                    w_cnt_nxt      = '0;
                    w_stop_sec_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!w_last_stop) begin
                        w_stop_sec_nxt = 1'b1;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + DIV_W'(1);
                    w_done_nxt = w_last_stop
                              && (r_cnt == r_n - DIV_W'(2));
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_cnt_nxt      = '0;
                w_idx_nxt      = '0;
                w_stop_sec_nxt = 1'b0;
            end
        endcase
    end

    // Line level for the upcoming cycle, so the output can be registered.
    always_comb begin
        w_line_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_line_nxt = 1'b0;
            DATA:    w_line_nxt = r_data[w_idx_nxt];
            PARITY:  w_line_nxt = w_parity_bit;
            default: w_line_nxt = 1'b1;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_sec <= 1'b0;
            r_line     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_stop_sec <= w_stop_sec_nxt;
            r_line     <= w_line_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Byte and frame format are captured together at pop time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_n     <= DIV_W'(UART_MIN_CLKS_PER_BIT);
            r_dbits <= '0;
            r_par   <= PAR_NONE;
            r_stop2 <= 1'b0;
        end else if (w_pop) begin
            r_data  <= w_fifo_rdata;
            r_n     <= w_n_cfg;
            r_dbits <= cfg_data_bits;
            r_par   <= decode_parity(cfg_parity);
            r_stop2 <= cfg_stop2;
        end
    end

endmodule
